// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the LUT sweep engine.
// State encoding, table depth derivation and signature rotate.
package lut_sweep_pkg;

   typedef enum logic {IDLE, SWEEP} state_t;

   function automatic int depth_of(input int in_w);
      return 1 << in_w;
   endfunction

   // Rotate left by one within a w-bit field held in 32 bits.
   function automatic logic [31:0] rotl1(input logic [31:0] v,
                                         input int          w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return ((v << 1) | (v >> (w - 1))) & mask;
   endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table storage: one sync write port, one async read port.
// Synchronous clear of every row on rst.
module lut_table_ram #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IN_W-1:0]  wa,
   input  logic [OUT_W-1:0] wd,
   input  logic [IN_W-1:0]  ra,
   output logic [OUT_W-1:0] rd
);

   logic [OUT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   assign rd = mem[ra];

endmodule

// File: rtl/lut_sweep_engine.sv
// Programmable truth-table engine with single lookup and full sweep.
// Sweep streams every row over ready/valid and folds a signature.
module lut_sweep_engine
   import lut_sweep_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IN_W-1:0]  wr_addr,
   input  logic [OUT_W-1:0] wr_data,
   output logic             wr_err,
   input  logic             eval_valid,
   input  logic [IN_W-1:0]  eval_in,
   output logic             eval_ready,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IN_W-1:0]  out_addr,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic [OUT_W-1:0] sig
);

   localparam int DEPTH = depth_of(IN_W);
   localparam logic [IN_W-1:0] LAST_ROW = IN_W'(DEPTH - 1);

   state_t          state_q, state_d;
   logic [IN_W:0]   idx_q, idx_d;
   logic            slot_free;
   logic            issue_eval, issue_sweep, issue;
   logic            ram_we, wr_err_d, done_d;
   logic            sig_clr, sig_upd;
   logic [IN_W-1:0] rd_addr;
   logic [OUT_W-1:0] rd_data;

   assign slot_free  = !out_valid || out_ready;
   assign sweep_busy = (state_q == SWEEP);
   assign eval_ready = (state_q == IDLE) && slot_free && !sweep_start;
   assign issue      = issue_eval || issue_sweep;

   lut_table_ram #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk (clk),
      .rst (rst),
      .we  (ram_we),
      .wa  (wr_addr),
      .wd  (wr_data),
      .ra  (rd_addr),
      .rd  (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      issue_eval  = eval_valid && eval_ready;
      issue_sweep = 1'b0;
      ram_we      = 1'b0;
      wr_err_d    = 1'b0;
      done_d      = 1'b0;
      sig_clr     = 1'b0;
      sig_upd     = 1'b0;
      rd_addr     = eval_in;
      unique case (state_q)
         IDLE: begin
            ram_we = wr_en;
            if (sweep_start && slot_free) begin
               state_d = SWEEP;
               idx_d   = '0;
               sig_clr = 1'b1;
            end
         end
         SWEEP: begin
            wr_err_d    = wr_en;
            rd_addr     = idx_q[IN_W-1:0];
            // idx stops at DEPTH; the top bit blocks further issue
            issue_sweep = slot_free && !idx_q[IN_W];
            if (issue_sweep) idx_d = idx_q + (IN_W+1)'(1);
            if (out_valid && out_ready) begin
               sig_upd = 1'b1;
               if (out_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         wr_err     <= 1'b0;
         sweep_done <= 1'b0;
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         out_last   <= 1'b0;
         sig        <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wr_err     <= wr_err_d;
         sweep_done <= done_d;
         if (sig_clr) begin
            sig <= '0;
         end else if (sig_upd) begin
            sig <= OUT_W'(rotl1(32'(sig), OUT_W)) ^ out_data;
         end
         if (slot_free) begin
            out_valid <= issue;
            if (issue) begin
               out_addr <= rd_addr;
               out_data <= rd_data;
               out_last <= issue_sweep && (rd_addr == LAST_ROW);
            end
         end
      end
   end

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Directed bench for lut_sweep_engine (IN_W=4, OUT_W=10).
// Hand-computed vectors checked with immediate assertions.
module tb_lut_sweep_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [9:0] wr_data;
   logic       wr_err;
   logic       eval_valid;
   logic [3:0] eval_in;
   logic       eval_ready;
   logic       sweep_start;
   logic       sweep_busy;
   logic       sweep_done;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_addr;
   logic [9:0] out_data;
   logic       out_last;
   logic [9:0] sig;

   int n_run  = 0;
   int n_fail = 0;
   logic [9:0] tbl [16];
   logic [9:0] exp_sig;
   int beats;
   int k;

   always #5 clk = ~clk;

   lut_sweep_engine #(.IN_W(4), .OUT_W(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_err      (wr_err),
      .eval_valid  (eval_valid),
      .eval_in     (eval_in),
      .eval_ready  (eval_ready),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .out_last    (out_last),
      .sig         (sig)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] rot(input logic [9:0] v);
      return {v[8:0], v[9]};
   endfunction

   task automatic do_eval(input logic [3:0] a);
      eval_valid = 1'b1;
      eval_in    = a;
      tick();
      eval_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      eval_valid = 1'b0; eval_in = '0; sweep_start = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", eval_ready, 1);
      chk("rst_busy", sweep_busy, 0);
      chk("rst_sig", sig, 0);
      chk("rst_data", out_data, 0);

      // T1 single write then lookup
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 10'h2A5;
      tick();
      wr_en = 1'b0;
      do_eval(4'd5);
      chk("t1_valid", out_valid, 1);
      chk("t1_addr", out_addr, 5);
      chk("t1_data", out_data, 10'h2A5);
      chk("t1_last", out_last, 0);
      tick();
      chk("t1_drain", out_valid, 0);

      // T6 read-before-write on the same row
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 10'h100;
      tick();
      wr_data = 10'h011;
      eval_valid = 1'b1; eval_in = 4'd2;
      tick();
      wr_en = 1'b0; eval_valid = 1'b0;
      chk("t6_old", out_data, 10'h100);
      do_eval(4'd2);
      chk("t6_new", out_data, 10'h011);
      tick();

      // T2 full sweep, no backpressure
      for (int i = 0; i < 16; i++) begin
         tbl[i] = 10'((i * 37) % 1024);
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = tbl[i];
         tick();
      end
      wr_en = 1'b0;
      exp_sig = '0;
      for (int i = 0; i < 16; i++) exp_sig = rot(exp_sig) ^ tbl[i];
      sweep_start = 1'b1; eval_valid = 1'b1; eval_in = 4'd1;
      #1;
      chk("t2_eval_blk", eval_ready, 0);
      tick();
      sweep_start = 1'b0; eval_valid = 1'b0;
      chk("t2_busy", sweep_busy, 1);
      chk("t2_nobeat", out_valid, 0);
      for (int b = 0; b < 16; b++) begin
         tick();
         chk($sformatf("t2_v%0d", b), out_valid, 1);
         chk($sformatf("t2_a%0d", b), out_addr, b);
         chk($sformatf("t2_d%0d", b), out_data, tbl[b]);
         chk($sformatf("t2_l%0d", b), out_last, (b == 15));
      end
      chk("t2_done_early", sweep_done, 0);
      tick();
      chk("t2_done", sweep_done, 1);
      chk("t2_idle", sweep_busy, 0);
      chk("t2_sig", sig, exp_sig);
      tick();
      chk("t2_done_pulse", sweep_done, 0);
      chk("t2_sig_hold", sig, exp_sig);

      // T3 stall three cycles on row 7
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         tick();
         chk($sformatf("t3_a%0d", b), out_addr, b);
      end
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk($sformatf("t3_hv%0d", s), out_valid, 1);
         chk($sformatf("t3_ha%0d", s), out_addr, 7);
         chk($sformatf("t3_hd%0d", s), out_data, tbl[7]);
      end
      out_ready = 1'b1;
      for (int b = 8; b < 16; b++) begin
         tick();
         chk($sformatf("t3_a%0d", b), out_addr, b);
      end
      tick();
      chk("t3_done", sweep_done, 1);
      chk("t3_sig", sig, exp_sig);

      // T4 write during sweep is dropped
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 10'h3FF;
      tick();
      wr_en = 1'b0;
      chk("t4_err", wr_err, 1);
      beats = out_valid ? 1 : 0;
      tick();
      chk("t4_err_pulse", wr_err, 0);
      k = 0;
      while (!sweep_done && k < 40) begin
         if (out_valid) beats++;
         tick();
         k++;
      end
      chk("t4_done", sweep_done, 1);
      chk("t4_beats", beats, 16);
      chk("t4_sig", sig, exp_sig);
      do_eval(4'd3);
      chk("t4_row3", out_data, tbl[3]);
      tick();

      // T5 reset in the middle of a sweep
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int b = 0; b < 10; b++) tick();
      chk("t5_at9", out_addr, 9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", out_valid, 0);
      chk("t5_busy", sweep_busy, 0);
      chk("t5_sig", sig, 0);
      chk("t5_done", sweep_done, 0);
      tick();
      chk("t5_done2", sweep_done, 0);
      do_eval(4'd5);
      chk("t5_row5", out_data, 0);
      chk("t5_ev_valid", out_valid, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
